// File: rtl/rvee_axilite_arb_if.sv
// AXI-Lite channel bundle shared by the arbiter's requester and memory-side ports.
interface rvee_axilite_arb_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic [AWIDTH-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DWIDTH-1:0]   wdata;
  logic [DWIDTH/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [AWIDTH-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DWIDTH-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  // Initiator side of the bus
  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  // Target side of the bus
  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/rvee_axilite_arb.sv
// Two-to-one AXI-Lite arbiter: FETCH (s00) and MEM (s01) share one master port
// (m00). One transaction in flight, round-robin between requesters, reads win
// over writes within a port.
module rvee_axilite_arb #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  rvee_axilite_arb_if.slave    s00,
  rvee_axilite_arb_if.slave    s01,
  rvee_axilite_arb_if.master   m00,
  output logic [1:0]           gnt
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;

  state_t state, state_nxt;
  logic   own, own_nxt;
  logic   lst, lst_nxt;
  logic   aw_done, aw_done_nxt;
  logic   w_done, w_done_nxt;
  logic   req0, req1, pick, aw_hs, w_hs;

  // Owner-selected requester signals
  logic [AWIDTH-1:0]   o_araddr, o_awaddr;
  logic [2:0]          o_arprot, o_awprot;
  logic [DWIDTH-1:0]   o_wdata;
  logic [DWIDTH/8-1:0] o_wstrb;
  logic                o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready;

  // Responses toward the owner, fanned out below
  logic                o_arready, o_awready, o_wready, o_rvalid, o_bvalid;
  logic [DWIDTH-1:0]   o_rdata;
  logic [1:0]          o_rresp, o_bresp;

  assign req0 = s00.arvalid | s00.awvalid;
  assign req1 = s01.arvalid | s01.awvalid;

  assign o_araddr  = own ? s01.araddr  : s00.araddr;
  assign o_arprot  = own ? s01.arprot  : s00.arprot;
  assign o_arvalid = own ? s01.arvalid : s00.arvalid;
  assign o_awaddr  = own ? s01.awaddr  : s00.awaddr;
  assign o_awprot  = own ? s01.awprot  : s00.awprot;
  assign o_awvalid = own ? s01.awvalid : s00.awvalid;
  assign o_wdata   = own ? s01.wdata   : s00.wdata;
  assign o_wstrb   = own ? s01.wstrb   : s00.wstrb;
  assign o_wvalid  = own ? s01.wvalid  : s00.wvalid;
  assign o_rready  = own ? s01.rready  : s00.rready;
  assign o_bready  = own ? s01.bready  : s00.bready;

  // Non-owner port sees zero on every response signal
  assign s00.arready = !own && o_arready;
  assign s00.awready = !own && o_awready;
  assign s00.wready  = !own && o_wready;
  assign s00.rvalid  = !own && o_rvalid;
  assign s00.bvalid  = !own && o_bvalid;
  assign s00.rdata   = own ? '0 : o_rdata;
  assign s00.rresp   = own ? '0 : o_rresp;
  assign s00.bresp   = own ? '0 : o_bresp;
  assign s01.arready = own && o_arready;
  assign s01.awready = own && o_awready;
  assign s01.wready  = own && o_wready;
  assign s01.rvalid  = own && o_rvalid;
  assign s01.bvalid  = own && o_bvalid;
  assign s01.rdata   = own ? o_rdata : '0;
  assign s01.rresp   = own ? o_rresp : '0;
  assign s01.bresp   = own ? o_bresp : '0;

  assign gnt = (state == IDLE) ? 2'b00 : {own, ~own};

  // State, owner, round-robin pointer and write-channel completion flags
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      own     <= 1'b0;
      lst     <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      own     <= own_nxt;
      lst     <= lst_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  // Arbitration, next state and per-state channel passthrough
  always_comb begin
    state_nxt   = state;
    own_nxt     = own;
    lst_nxt     = lst;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    pick        = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    m00.araddr  = '0;
    m00.arprot  = '0;
    m00.arvalid = 1'b0;
    m00.rready  = 1'b0;
    m00.awaddr  = '0;
    m00.awprot  = '0;
    m00.awvalid = 1'b0;
    m00.wdata   = '0;
    m00.wstrb   = '0;
    m00.wvalid  = 1'b0;
    m00.bready  = 1'b0;
    o_arready   = 1'b0;
    o_awready   = 1'b0;
    o_wready    = 1'b0;
    o_rvalid    = 1'b0;
    o_bvalid    = 1'b0;
    o_rdata     = '0;
    o_rresp     = '0;
    o_bresp     = '0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          pick      = (req0 && req1) ? ~lst : req1;
          own_nxt   = pick;
          state_nxt = (pick ? s01.arvalid : s00.arvalid) ? RADDR : WADDR;
        end
      end
      RADDR: begin
        m00.araddr  = o_araddr;
        m00.arprot  = o_arprot;
        m00.arvalid = o_arvalid;
        o_arready   = m00.arready;
        if (o_arvalid && m00.arready) state_nxt = RDATA;
      end
      RDATA: begin
        o_rdata    = m00.rdata;
        o_rresp    = m00.rresp;
        o_rvalid   = m00.rvalid;
        m00.rready = o_rready;
        if (m00.rvalid && o_rready) begin
          state_nxt = IDLE;
          lst_nxt   = own;
        end
      end
      WADDR: begin
        // A channel that has already handshaken is masked so it cannot fire twice.
        m00.awaddr  = o_awaddr;
        m00.awprot  = o_awprot;
        m00.awvalid = o_awvalid && !aw_done;
        o_awready   = m00.awready && !aw_done;
        m00.wdata   = o_wdata;
        m00.wstrb   = o_wstrb;
        m00.wvalid  = o_wvalid && !w_done;
        o_wready    = m00.wready && !w_done;
        aw_hs       = o_awvalid && !aw_done && m00.awready;
        w_hs        = o_wvalid && !w_done && m00.wready;
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nxt   = WRESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          aw_done_nxt = aw_done || aw_hs;
          w_done_nxt  = w_done || w_hs;
        end
      end
      WRESP: begin
        o_bresp    = m00.bresp;
        o_bvalid   = m00.bvalid;
        m00.bready = o_bready;
        if (m00.bvalid && o_bready) begin
          state_nxt = IDLE;
          lst_nxt   = own;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
